// File: rtl/fetch_redirect_pkg.sv
// Shared widths, constants, payload types and helpers for the fetch/redirect unit.
package fetch_redirect_pkg;

  localparam int unsigned ADDR_WIDTH = 32;
  localparam int unsigned DATA_WIDTH = 32;

  localparam logic [ADDR_WIDTH-1:0] ZERO     = '0;
  localparam logic [DATA_WIDTH-1:0] INST_NOP = 32'h0000_0013;
  localparam logic [ADDR_WIDTH-1:0] RESET_PC = 32'h0000_0000;
  localparam logic [ADDR_WIDTH-1:0] PC_STEP  = ADDR_WIDTH'(4);

  // One buffered fetch result: instruction word plus the address it came from.
  typedef struct packed {
    logic [DATA_WIDTH-1:0] inst;
    logic [ADDR_WIDTH-1:0] addr;
  } fetch_entry_t;

  // Force a byte address onto a word boundary.
  function automatic logic [ADDR_WIDTH-1:0] word_align(input logic [ADDR_WIDTH-1:0] a);
    return {a[ADDR_WIDTH-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_redirect_if.sv
// Instruction-bus and decode-side handshake bundle of the fetch unit.
//   master : the fetch unit (drives bus request/address and decode-side valid/inst/addr)
//   slave  : the environment (bus grant/response, decode ready)
interface fetch_redirect_if;
  import fetch_redirect_pkg::*;

  // instruction bus
  logic                  inst_req_o;
  logic [ADDR_WIDTH-1:0] inst_addr_o;
  logic                  inst_gnt_i;
  logic                  inst_rvalid_i;
  logic [DATA_WIDTH-1:0] inst_rdata_i;

  // decode side
  logic                  if_valid_o;
  logic                  if_ready_i;
  logic [DATA_WIDTH-1:0] if_inst_o;
  logic [ADDR_WIDTH-1:0] if_inst_addr_o;

  modport master (
    output inst_req_o, inst_addr_o, if_valid_o, if_inst_o, if_inst_addr_o,
    input  inst_gnt_i, inst_rvalid_i, inst_rdata_i, if_ready_i
  );

  modport slave (
    input  inst_req_o, inst_addr_o, if_valid_o, if_inst_o, if_inst_addr_o,
    output inst_gnt_i, inst_rvalid_i, inst_rdata_i, if_ready_i
  );

endinterface

// File: rtl/fetch_redirect_fetch_buf.sv
// fetch_buf: one-entry holding register between the instruction bus and decode.
//   clk_i, rst_i : clock, synchronous active-high reset
//   load_i       : capture entry_i and mark valid
//   clear_i      : drop the held entry (redirect); wins over load and consume
//   consume_i    : decode took the entry; empties unless reloaded the same cycle
//   entry_i      : incoming {inst, addr}
//   valid_o      : entry held
//   entry_o      : held {inst, addr}, stable until consumed or replaced
module fetch_buf
  import fetch_redirect_pkg::*;
(
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic         clear_i,
  input  logic         consume_i,
  input  fetch_entry_t entry_i,
  output logic         valid_o,
  output fetch_entry_t entry_o
);

  // Payload is only rewritten on load so it stays stable under back-pressure.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_o       <= 1'b0;
      entry_o.inst  <= INST_NOP;
      entry_o.addr  <= ZERO;
    end else if (clear_i) begin
      valid_o <= 1'b0;
    end else if (load_i) begin
      valid_o <= 1'b1;
      entry_o <= entry_i;
    end else if (consume_i) begin
      valid_o <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_redirect.sv
// fetch_redirect: single-outstanding instruction fetcher with jump redirect.
//   clk_i, rst_i   : clock, synchronous active-high reset
//   jump_enable_i  : redirect request from execute; highest priority event
//   jump_addr_i    : redirect target (low two bits dropped, flagged via misalign_o)
//   hold_i         : pipeline stall; blocks issuing new requests only
//   bus            : instruction bus + decode handshake (master side)
//   flush_o        : combinational, jump_enable_i & ~rst_i; kills younger stages
//   misalign_o     : registered one-cycle pulse for a redirect target with addr[1:0] != 0
module fetch_redirect
  import fetch_redirect_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  jump_enable_i,
  input  logic [ADDR_WIDTH-1:0] jump_addr_i,
  input  logic                  hold_i,
  fetch_redirect_if.master      bus,
  output logic                  flush_o,
  output logic                  misalign_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_RSP   = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  state_t                state_q;
  logic [ADDR_WIDTH-1:0] pc_q;
  logic [ADDR_WIDTH-1:0] issued_q;
  logic                  misalign_q;

  logic                  redirect;
  logic                  req;
  logic                  granted;
  logic                  buf_load;
  logic                  buf_valid;
  fetch_entry_t          buf_entry;
  fetch_entry_t          rsp_entry;

  assign redirect = jump_enable_i & ~rst_i;

  // Issue only when the buffer is empty or draining this cycle, so a response always has room.
  assign req      = ~rst_i & (state_q == ST_REQ) & ~hold_i & (~buf_valid | bus.if_ready_i);
  assign granted  = req & bus.inst_gnt_i;

  // A response coinciding with a redirect belongs to the old stream and is dropped.
  assign buf_load = (state_q == ST_RSP) & bus.inst_rvalid_i & ~redirect;

  assign rsp_entry.inst = bus.inst_rdata_i;
  assign rsp_entry.addr = issued_q;

  // FSM, pc and misalign pulse.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      pc_q       <= RESET_PC;
      issued_q   <= RESET_PC;
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= redirect & (|jump_addr_i[1:0]);
      unique case (state_q)
        ST_IDLE: state_q <= ST_REQ;
        ST_REQ: begin
          if (granted) begin
            issued_q <= pc_q;
            // A grant alongside a redirect still leaves a response to swallow.
            state_q  <= redirect ? ST_DRAIN : ST_RSP;
          end
        end
        ST_RSP: begin
          if (redirect) begin
            state_q <= bus.inst_rvalid_i ? ST_REQ : ST_DRAIN;
          end else if (bus.inst_rvalid_i) begin
            pc_q    <= pc_q + PC_STEP;
            state_q <= ST_REQ;
          end
        end
        ST_DRAIN: begin
          if (bus.inst_rvalid_i) state_q <= ST_REQ;
        end
        default: state_q <= ST_IDLE;
      endcase
      // Redirect overrides any sequential pc update; equal targets still refetch.
      if (redirect) pc_q <= word_align(jump_addr_i);
    end
  end

  fetch_buf u_fetch_buf (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .load_i    (buf_load),
    .clear_i   (redirect),
    .consume_i (buf_valid & bus.if_ready_i),
    .entry_i   (rsp_entry),
    .valid_o   (buf_valid),
    .entry_o   (buf_entry)
  );

  assign bus.inst_req_o     = req;
  assign bus.inst_addr_o    = pc_q;
  assign bus.if_valid_o     = buf_valid;
  assign bus.if_inst_o      = buf_entry.inst;
  assign bus.if_inst_addr_o = buf_entry.addr;
  assign flush_o            = redirect;
  assign misalign_o         = misalign_q;

endmodule

// File: tb/tb_fetch_redirect.sv
// Self-checking bench for fetch_redirect: vector table, directed corner sequences,
// and randomized traffic checked against a stream-level reference model.
module tb_fetch_redirect;
  import fetch_redirect_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_i;
  logic        jump_enable_i;
  logic [31:0] jump_addr_i;
  logic        hold_i;
  logic        flush_o;
  logic        misalign_o;

  fetch_redirect_if fr_if ();

  fetch_redirect dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .jump_enable_i (jump_enable_i),
    .jump_addr_i   (jump_addr_i),
    .hold_i        (hold_i),
    .bus           (fr_if),
    .flush_o       (flush_o),
    .misalign_o    (misalign_o)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // stimulus controls
  logic        drv_rst, drv_jump, drv_hold, drv_ready, gnt_en;
  logic [31:0] drv_jaddr;
  int          gnt_pct, lat_min, lat_max;

  // bus responder
  logic        out_busy;
  int          out_cnt;
  logic [31:0] out_addr;

  // reference model: next address decode must receive, and accepted stream
  logic [31:0] exp_next;
  logic        exp_mis;
  logic [31:0] acc_q[$];

  // previous-cycle snapshot
  logic        p_valid, p_ready, p_jump, p_rst;
  logic [31:0] p_inst, p_iaddr;

  // current-cycle samples
  logic        s_req, s_rvalid, s_flush, s_mis, s_valid;
  logic [31:0] s_addr, s_inst, s_iaddr;

  typedef struct {
    logic        jump;
    logic [31:0] addr;
    logic        exp_flush;
    logic        exp_mis;
    logic [31:0] exp_pc;
  } vec_t;
  vec_t vecs[6];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // One clock: drive on negedge, sample after settling, check, advance models.
  task automatic step();
    @(negedge clk);
    rst_i               = drv_rst;
    jump_enable_i       = drv_jump;
    jump_addr_i         = drv_jaddr;
    hold_i              = drv_hold;
    fr_if.if_ready_i    = drv_ready;
    fr_if.inst_rvalid_i = out_busy && (out_cnt == 0);
    fr_if.inst_rdata_i  = out_busy ? mem_word(out_addr) : $urandom();
    fr_if.inst_gnt_i    = gnt_en && (int'($urandom_range(99)) < gnt_pct);
    #1;
    s_req    = fr_if.inst_req_o;
    s_addr   = fr_if.inst_addr_o;
    s_rvalid = fr_if.inst_rvalid_i;
    s_valid  = fr_if.if_valid_o;
    s_inst   = fr_if.if_inst_o;
    s_iaddr  = fr_if.if_inst_addr_o;
    s_flush  = flush_o;
    s_mis    = misalign_o;

    chk1("flush", s_flush, drv_jump & ~drv_rst);
    chk1("misalign", s_mis, exp_mis);
    if (!drv_rst) begin
      if (drv_hold) chk1("hold_blocks_req", s_req, 1'b0);
      if (out_busy) chk1("one_outstanding", s_req, 1'b0);
      if (p_jump)   chk1("valid_after_redirect", s_valid, 1'b0);
      if (p_valid && !p_ready && !p_jump && !p_rst) begin
        chk1("buf_hold_valid", s_valid, 1'b1);
        chk("buf_hold_inst", s_inst, p_inst);
        chk("buf_hold_addr", s_iaddr, p_iaddr);
      end
      if (s_valid && drv_ready && !drv_jump) begin
        chk("accept_addr", s_iaddr, exp_next);
        chk("accept_inst", s_inst, mem_word(exp_next));
        acc_q.push_back(s_iaddr);
        exp_next = exp_next + 32'd4;
      end
      if (drv_jump) exp_next = {drv_jaddr[31:2], 2'b00};
    end

    if (drv_rst) begin
      out_busy = 1'b0;
    end else begin
      if (s_rvalid) out_busy = 1'b0;
      else if (out_busy) out_cnt--;
      if (s_req && fr_if.inst_gnt_i) begin
        out_busy = 1'b1;
        out_cnt  = int'($urandom_range(lat_max, lat_min)) - 1;
        out_addr = s_addr;
      end
    end

    exp_mis = drv_jump && !drv_rst && (drv_jaddr[1:0] != 2'b00);
    if (drv_rst) exp_next = RESET_PC;
    p_valid = s_valid;
    p_ready = drv_ready;
    p_jump  = drv_jump & ~drv_rst;
    p_rst   = drv_rst;
    p_inst  = s_inst;
    p_iaddr = s_iaddr;
  endtask

  task automatic do_reset();
    drv_rst = 1'b1; drv_jump = 1'b0; drv_hold = 1'b0; drv_ready = 1'b1; drv_jaddr = '0;
    gnt_en = 1'b0; gnt_pct = 100; lat_min = 1; lat_max = 1;
    step();
    step();
    drv_rst = 1'b0;
    acc_q.delete();
  endtask

  task automatic check_reset_vals(input string tag);
    chk1({tag, "_req"}, s_req, 1'b0);
    chk({tag, "_addr"}, s_addr, RESET_PC);
    chk1({tag, "_valid"}, s_valid, 1'b0);
    chk({tag, "_inst"}, s_inst, INST_NOP);
    chk({tag, "_iaddr"}, s_iaddr, ZERO);
    chk1({tag, "_mis"}, s_mis, 1'b0);
  endtask

  task automatic run_until_acc(input int n, input int budget, input string tag);
    int k;
    k = 0;
    while (acc_q.size() < n && k < budget) begin
      step();
      k++;
    end
    chk1({tag, "_timeout"}, acc_q.size() >= n, 1'b1);
  endtask

  initial begin
    logic [31:0] inst0;
    int          k;
    int          r;

    rst_i = 1'b1; jump_enable_i = 1'b0; jump_addr_i = '0; hold_i = 1'b0;
    fr_if.inst_gnt_i = 1'b0; fr_if.inst_rvalid_i = 1'b0; fr_if.inst_rdata_i = '0;
    fr_if.if_ready_i = 1'b1;
    out_busy = 1'b0; out_cnt = 0; out_addr = '0;
    exp_next = RESET_PC; exp_mis = 1'b0;
    p_valid = 1'b0; p_ready = 1'b0; p_jump = 1'b0; p_rst = 1'b1; p_inst = '0; p_iaddr = '0;

    vecs[0] = '{1'b1, 32'h0000_0103, 1'b1, 1'b1, 32'h0000_0100};
    vecs[1] = '{1'b1, 32'h0000_0200, 1'b1, 1'b0, 32'h0000_0200};
    vecs[2] = '{1'b0, 32'h0000_0777, 1'b0, 1'b0, 32'h0000_0200};
    vecs[3] = '{1'b1, 32'hFFFF_FFFE, 1'b1, 1'b1, 32'hFFFF_FFFC};
    vecs[4] = '{1'b1, 32'h0000_0003, 1'b1, 1'b1, 32'h0000_0000};
    vecs[5] = '{1'b1, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000};

    // Reset values, then redirect table applied in REQ with the bus never granting.
    do_reset();
    step();
    check_reset_vals("rst");
    foreach (vecs[i]) begin
      drv_jump = vecs[i].jump; drv_jaddr = vecs[i].addr;
      step();
      chk1($sformatf("vec%0d_flush", i), s_flush, vecs[i].exp_flush);
      drv_jump = 1'b0;
      step();
      chk1($sformatf("vec%0d_mis", i), s_mis, vecs[i].exp_mis);
      chk($sformatf("vec%0d_pc", i), s_addr, vecs[i].exp_pc);
      chk1($sformatf("vec%0d_req", i), s_req, 1'b1);
    end

    // In-order fetch of 0x0, 0x4, 0x8 with an always-granting, one-cycle bus.
    do_reset();
    gnt_en = 1'b1;
    run_until_acc(3, 40, "seq_order");
    if (acc_q.size() >= 3) begin
      chk("seq_order_0", acc_q[0], 32'h0);
      chk("seq_order_1", acc_q[1], 32'h4);
      chk("seq_order_2", acc_q[2], 32'h8);
    end

    // Redirect while waiting for a response: drain it, then fetch the target.
    do_reset();
    drv_jump = 1'b1; drv_jaddr = 32'h10;
    step();
    drv_jump = 1'b0; gnt_en = 1'b1; lat_min = 3; lat_max = 3;
    step();
    chk1("drain_issue_req", s_req, 1'b1);
    chk("drain_issue_addr", s_addr, 32'h10);
    drv_jump = 1'b1; drv_jaddr = 32'h200;
    step();
    chk1("drain_flush", s_flush, 1'b1);
    chk1("drain_rsp_noreq", s_req, 1'b0);
    drv_jump = 1'b0;
    step();
    chk1("drain_wait_noreq", s_req, 1'b0);
    chk("drain_wait_addr", s_addr, 32'h200);
    step();
    chk1("drain_rvalid", s_rvalid, 1'b1);
    chk1("drain_rvalid_noreq", s_req, 1'b0);
    step();
    chk1("drain_refetch_req", s_req, 1'b1);
    chk("drain_refetch_addr", s_addr, 32'h200);
    chk1("drain_dropped", s_valid, 1'b0);
    run_until_acc(1, 20, "drain_acc");
    if (acc_q.size() >= 1) chk("drain_acc_addr", acc_q[0], 32'h200);

    // PC wraps from the top of the address space.
    do_reset();
    drv_jump = 1'b1; drv_jaddr = 32'hFFFF_FFFC;
    step();
    drv_jump = 1'b0; gnt_en = 1'b1;
    run_until_acc(2, 30, "wrap");
    if (acc_q.size() >= 2) begin
      chk("wrap_0", acc_q[0], 32'hFFFF_FFFC);
      chk("wrap_1", acc_q[1], 32'h0);
    end

    // Decode back-pressure and hold both block requests; release resumes at pc.
    do_reset();
    gnt_en = 1'b1; drv_ready = 1'b0;
    k = 0;
    do begin
      step();
      k++;
    end while (!s_valid && k < 20);
    chk1("bp_fill", s_valid, 1'b1);
    inst0 = mem_word(32'h0);
    for (int c = 0; c < 5; c++) begin
      step();
      chk1("bp_noreq", s_req, 1'b0);
      chk("bp_inst", s_inst, inst0);
      chk("bp_iaddr", s_iaddr, 32'h0);
    end
    drv_ready = 1'b1; drv_hold = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      chk1("hold_noreq", s_req, 1'b0);
    end
    drv_hold = 1'b0;
    step();
    chk1("hold_release_req", s_req, 1'b1);
    chk("hold_release_addr", s_addr, 32'h4);

    // Reset while a response is outstanding.
    do_reset();
    gnt_en = 1'b1; lat_min = 3; lat_max = 3;
    step();
    step();
    chk1("rstmid_issue", s_req, 1'b1);
    step();
    drv_rst = 1'b1;
    step();
    drv_rst = 1'b0; lat_min = 1; lat_max = 1;
    acc_q.delete();
    step();
    check_reset_vals("rstmid");
    run_until_acc(1, 20, "rstmid_acc");
    if (acc_q.size() >= 1) chk("rstmid_first", acc_q[0], RESET_PC);

    // Randomized traffic against the stream model.
    do_reset();
    gnt_en = 1'b1; gnt_pct = 50; lat_min = 1; lat_max = 3;
    for (int c = 0; c < 3000; c++) begin
      drv_jump  = ($urandom_range(15) == 0);
      r         = int'($urandom_range(3));
      case (r)
        0:       drv_jaddr = $urandom();
        1:       drv_jaddr = exp_next;
        2:       drv_jaddr = 32'hFFFF_FFF0 + 32'($urandom_range(15));
        default: drv_jaddr = 32'($urandom_range(255));
      endcase
      drv_hold  = ($urandom_range(7) == 0);
      drv_ready = ($urandom_range(3) != 0);
      step();
    end
    chk1("random_progress", acc_q.size() > 100, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
